// File: rtl/floo_serial_link_vc_arbiter.sv
// Serial-link VC arbiter: sticky round-robin with burst limit, per-VC credits, one registered output flit.
// Optional perf counters enabled by defining SERIAL_LINK_VC_ARB_PERF_EN.
module floo_serial_link_vc_arbiter #(
  parameter int NumVc      = 3,
  parameter int FlitWidth  = 64,
  parameter int NumCredits = 8,
  parameter int MaxBurst   = 4,
  parameter int CntW       = $clog2(NumCredits+1),
  parameter int VcW        = $clog2(NumVc)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NumVc-1:0]          vc_valid_i,
  output logic [NumVc-1:0]          vc_ready_o,
  input  logic [NumVc*FlitWidth-1:0] vc_data_i,
  output logic                      link_valid_o,
  input  logic                      link_ready_i,
  output logic [FlitWidth-1:0]      link_data_o,
  output logic [VcW-1:0]            link_vc_o,
  input  logic [NumVc-1:0]          credit_ret_i,
  output logic [NumVc*CntW-1:0]     credits_o,
  output logic                      credit_err_o,
  output logic [NumVc*16-1:0]       perf_grant_o,
  output logic [15:0]               perf_stall_o
);
  localparam int BurstW = $clog2(MaxBurst+1);

  logic                              r_valid;
  logic [FlitWidth-1:0]              r_data;
  logic [VcW-1:0]                    r_vc;
  logic [VcW-1:0]                    r_last;
  logic [BurstW-1:0]                 r_burst;
  logic [CntW-1:0]                   r_cred [NumVc];
  logic                              r_err;

  logic [NumVc-1:0][FlitWidth-1:0]   w_vc_data;
  logic [NumVc-1:0]                  w_elig;
  logic [NumVc-1:0]                  w_full;
  logic [NumVc-1:0]                  w_gnt_oh;
  logic [VcW-1:0]                    w_gnt_idx;
  logic                              w_slot_free;
  logic                              w_only_last;
  logic                              w_keep;
  logic                              w_found;
  logic                              w_gnt;

  assign w_vc_data   = vc_data_i;
  assign w_slot_free = !r_valid || link_ready_i;

  for (genvar i = 0; i < NumVc; i++) begin : g_vc
    assign w_elig[i] = vc_valid_i[i] && (r_cred[i] != '0) && enable_i;
    assign w_full[i] = (r_cred[i] == CntW'(NumCredits));
    assign credits_o[i*CntW +: CntW] = r_cred[i];

    always_ff @(posedge clk_i) begin
      if (!rst_ni)
        r_cred[i] <= CntW'(NumCredits);
      else if (w_gnt_oh[i] && !credit_ret_i[i])
        r_cred[i] <= r_cred[i] - CntW'(1);
      else if (!w_gnt_oh[i] && credit_ret_i[i] && !w_full[i])
        r_cred[i] <= r_cred[i] + CntW'(1);
    end
  end

  // Burst count 0 only exists right after reset: no sticky preference yet, so VC0 wins first.
  always_comb begin
    int idx;
    w_only_last = ((w_elig & ~(NumVc'(1) << r_last)) == '0);
    w_keep      = w_elig[r_last] &&
                  (((r_burst != '0) && (r_burst < BurstW'(MaxBurst))) || w_only_last);
    w_gnt_idx   = r_last;
    w_found     = 1'b0;
    idx         = 0;
    if (!w_keep) begin
      for (int k = 1; k <= NumVc; k++) begin
        idx = int'(r_last) + k;
        if (idx >= NumVc) idx = idx - NumVc;
        if (!w_found && w_elig[idx]) begin
          w_found   = 1'b1;
          w_gnt_idx = VcW'(idx);
        end
      end
    end
    w_gnt    = rst_ni && w_slot_free && (w_elig != '0);
    w_gnt_oh = w_gnt ? (NumVc'(1) << w_gnt_idx) : '0;
  end

  assign vc_ready_o = w_gnt_oh;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_vc    <= '0;
      r_last  <= VcW'(NumVc-1);
      r_burst <= '0;
    end else if (w_gnt) begin
      r_valid <= 1'b1;
      r_data  <= w_vc_data[w_gnt_idx];
      r_vc    <= w_gnt_idx;
      r_last  <= w_gnt_idx;
      if (w_gnt_idx != r_last)
        r_burst <= BurstW'(1);
      else if (r_burst != BurstW'(MaxBurst))
        r_burst <= r_burst + BurstW'(1);
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      r_err <= 1'b0;
    else if ((credit_ret_i & ~w_gnt_oh & w_full) != '0)
      r_err <= 1'b1;
  end

  assign link_valid_o = r_valid;
  assign link_data_o  = r_data;
  assign link_vc_o    = r_vc;
  assign credit_err_o = r_err;

`ifdef SERIAL_LINK_VC_ARB_PERF_EN
  logic [15:0] r_perf_grant [NumVc];
  logic [15:0] r_perf_stall;

  for (genvar i = 0; i < NumVc; i++) begin : g_perf
    assign perf_grant_o[i*16 +: 16] = r_perf_grant[i];
    always_ff @(posedge clk_i) begin
      if (!rst_ni)
        r_perf_grant[i] <= '0;
      else if (w_gnt_oh[i] && (r_perf_grant[i] != 16'hFFFF))
        r_perf_grant[i] <= r_perf_grant[i] + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      r_perf_stall <= '0;
    else if (r_valid && !link_ready_i && (r_perf_stall != 16'hFFFF))
      r_perf_stall <= r_perf_stall + 16'd1;
  end

  assign perf_stall_o = r_perf_stall;
`else
  assign perf_grant_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_floo_serial_link_vc_arbiter.sv
// Directed bench for floo_serial_link_vc_arbiter: per-cycle vector table plus a hand-written stall sequence.
module tb_floo_serial_link_vc_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [2:0]   vld;
  logic [2:0]   rdy;
  logic [191:0] vc_data;
  logic         lv;
  logic         lrdy;
  logic [63:0]  ldata;
  logic [1:0]   lvc;
  logic [2:0]   ret;
  logic [11:0]  cred;
  logic         err;
  logic [47:0]  pgrant;
  logic [15:0]  pstall;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  floo_serial_link_vc_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .vc_valid_i(vld), .vc_ready_o(rdy), .vc_data_i(vc_data),
    .link_valid_o(lv), .link_ready_i(lrdy), .link_data_o(ldata), .link_vc_o(lvc),
    .credit_ret_i(ret), .credits_o(cred), .credit_err_o(err),
    .perf_grant_o(pgrant), .perf_stall_o(pstall)
  );

  typedef struct {
    logic       rst_n, en;
    logic [2:0] vld;
    logic       lrdy;
    logic [2:0] ret;
    logic [2:0] rdy;
    logic       lv;
    logic [1:0] lvc;
    logic [11:0] cred;
    logic       err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] dat(int i);
    return 64'hF00D_0000_0000_0000 + 64'(i);
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(logic r, logic e, logic [2:0] v, logic l, logic [2:0] rt,
                     logic [2:0] er, logic elv, logic [1:0] elvc, logic [11:0] ec, logic ee);
    vec_t t;
    t.rst_n = r; t.en = e; t.vld = v; t.lrdy = l; t.ret = rt;
    t.rdy = er; t.lv = elv; t.lvc = elvc; t.cred = ec; t.err = ee;
    vq.push_back(t);
  endtask

  task automatic reset_row();
    add(0, 1, 3'b000, 1, 3'b000, 3'b000, 0, 2'd0, 12'h888, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; vld = '0; lrdy = 1'b1; ret = '0;
    for (int i = 0; i < 3; i++) vc_data[i*64 +: 64] = dat(i);

    // Round-robin with burst limit 4, from VC0 after reset
    reset_row();
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h887, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h886, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h885, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h884, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b010, 1, 2'd1, 12'h874, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b010, 1, 2'd1, 12'h864, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b010, 1, 2'd1, 12'h854, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b010, 1, 2'd1, 12'h844, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b100, 1, 2'd2, 12'h744, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b100, 1, 2'd2, 12'h644, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b100, 1, 2'd2, 12'h544, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b100, 1, 2'd2, 12'h444, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h443, 0);
    add(1, 1, 3'b000, 1, 3'b010, 3'b000, 0, 2'd0, 12'h453, 0);

    // VC2 alone exhausts its credits, then one return buys one grant
    reset_row();
    for (int k = 7; k >= 0; k--)
      add(1, 1, 3'b100, 1, 3'b000, 3'b100, 1, 2'd2, {4'(k), 8'h88}, 0);
    add(1, 1, 3'b100, 1, 3'b000, 3'b000, 0, 2'd0, 12'h088, 0);
    add(1, 1, 3'b100, 1, 3'b000, 3'b000, 0, 2'd0, 12'h088, 0);
    add(1, 1, 3'b100, 1, 3'b100, 3'b000, 0, 2'd0, 12'h188, 0);
    add(1, 1, 3'b100, 1, 3'b000, 3'b100, 1, 2'd2, 12'h088, 0);
    add(1, 1, 3'b100, 1, 3'b000, 3'b000, 0, 2'd0, 12'h088, 0);

    // VC1 alone: 10 back-to-back, grant+return holds count, then overflow return on VC0
    reset_row();
    for (int k = 0; k < 10; k++)
      add(1, 1, 3'b010, 1, (k >= 5) ? 3'b010 : 3'b000, 3'b010, 1, 2'd1,
          {4'h8, (k >= 5) ? 4'd3 : 4'(7 - k), 4'h8}, 0);
    add(1, 1, 3'b000, 1, 3'b001, 3'b000, 0, 2'd0, 12'h838, 1);
    add(1, 1, 3'b000, 1, 3'b000, 3'b000, 0, 2'd0, 12'h838, 1);

    // enable dropped while the flit is held; returns still counted
    reset_row();
    add(1, 1, 3'b001, 1, 3'b000, 3'b001, 1, 2'd0, 12'h887, 0);
    add(1, 0, 3'b001, 0, 3'b000, 3'b000, 1, 2'd0, 12'h887, 0);
    add(1, 0, 3'b001, 0, 3'b000, 3'b000, 1, 2'd0, 12'h887, 0);
    add(1, 0, 3'b001, 1, 3'b001, 3'b000, 0, 2'd0, 12'h888, 0);
    add(1, 0, 3'b001, 1, 3'b000, 3'b000, 0, 2'd0, 12'h888, 0);

    // reset in the middle of a burst
    reset_row();
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h887, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h886, 0);
    add(0, 1, 3'b111, 1, 3'b000, 3'b000, 0, 2'd0, 12'h888, 0);
    add(1, 1, 3'b111, 1, 3'b000, 3'b001, 1, 2'd0, 12'h887, 0);

    foreach (vq[n]) begin
      @(negedge clk);
      rst_n = vq[n].rst_n; en = vq[n].en; vld = vq[n].vld;
      lrdy = vq[n].lrdy; ret = vq[n].ret;
      #1;
      chk("vc_ready", n, 64'(rdy), 64'(vq[n].rdy));
      @(posedge clk);
      #1;
      chk("link_valid", n, 64'(lv), 64'(vq[n].lv));
      if (vq[n].lv) begin
        chk("link_vc", n, 64'(lvc), 64'(vq[n].lvc));
        chk("link_data", n, ldata, dat(int'(vq[n].lvc)));
      end
      if (!vq[n].rst_n) begin
        chk("rst_link_vc", n, 64'(lvc), 64'd0);
        chk("rst_link_data", n, ldata, 64'd0);
      end
      chk("credits", n, 64'(cred), 64'(vq[n].cred));
      chk("credit_err", n, 64'(err), 64'(vq[n].err));
    end

    // Link stall: output holds while the source data keeps changing
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; vld = '0; lrdy = 1'b1; ret = '0;
    @(negedge clk);
    rst_n = 1'b1; vld = 3'b001; vc_data[63:0] = 64'h1111_1111_1111_1111;
    @(posedge clk);
    #1;
    chk("stall_first_valid", 0, 64'(lv), 64'd1);
    chk("stall_first_data", 0, ldata, 64'h1111_1111_1111_1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lrdy = 1'b0;
      vc_data[63:0] = 64'h2222_0000_0000_0000 + 64'(k);
      #1;
      chk("stall_ready", k, 64'(rdy), 64'd0);
      @(posedge clk);
      #1;
      chk("stall_valid", k, 64'(lv), 64'd1);
      chk("stall_data", k, ldata, 64'h1111_1111_1111_1111);
    end
    @(negedge clk);
    vld = '0; lrdy = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_drain", 0, 64'(lv), 64'd0);
`ifdef SERIAL_LINK_VC_ARB_PERF_EN
    chk("perf_stall", 0, 64'(pstall), 64'd5);
    chk("perf_grant0", 0, 64'(pgrant[15:0]), 64'd1);
`else
    chk("perf_stall_tied", 0, 64'(pstall), 64'd0);
    chk("perf_grant_tied", 0, 64'(pgrant), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
